// File: rtl/am_modem_core.sv
`default_nettype none
// ============================================================================
// Module   : am_modem_core
// Purpose  : Configurable AM modem datapath. It sits between the ADC capture
//            registers and the DAC output register.
//            mode=0 (modulate): the message is scaled by gain/4 with
//            saturation, offset to unsigned, then multiplied by the carrier.
//            mode=1 (demodulate): the RF sample is full-wave rectified, then
//            boxcar-averaged over 2^AVG_LOG2 samples.
//            All pin-level data is offset binary. Latency is 3 cycles after
//            the accepting edge.
// Ports    : CLK        - clock for all logic
//            RST_n      - synchronous active-low reset
//            mode       - 0 = modulate, 1 = demodulate
//            gain       - unsigned message gain, applied as gain/4
//            msg_data   - message sample (offset binary), msg_valid qualifier
//            car_data   - carrier / RF sample (offset binary), car_valid qual.
//            out_data   - result (offset binary when modulating, unsigned
//                         envelope when demodulating)
//            out_valid  - one-cycle strobe per result
//            sat_flag   - sticky gain-saturation flag
//            env_max/env_min/meter_valid - depth meter (AM_DEPTH_METER_EN)
// Option   : define AM_DEPTH_METER_EN to add the modulation-depth meter.
// Revision : 1.0 - initial release
// ============================================================================
module am_modem_core #(
  parameter int MSG_W    = 12,
  parameter int CAR_W    = 8,
  parameter int OUT_W    = 14,
  parameter int GAIN_W   = 4,
  parameter int AVG_LOG2 = 4
`ifdef AM_DEPTH_METER_EN
  , parameter int METER_LOG2 = 10
`endif
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              mode,
  input  logic [GAIN_W-1:0] gain,
  input  logic [MSG_W-1:0]  msg_data,
  input  logic              msg_valid,
  input  logic [CAR_W-1:0]  car_data,
  input  logic              car_valid,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  output logic              sat_flag
`ifdef AM_DEPTH_METER_EN
  , output logic [MSG_W-1:0] env_max,
  output logic [MSG_W-1:0]   env_min,
  output logic               meter_valid
`endif
);

  localparam int c_PW    = MSG_W + GAIN_W + 1;      // gain product width
  localparam int c_P2W   = MSG_W + CAR_W + 1;       // carrier product width
  localparam int c_SH    = MSG_W + CAR_W - OUT_W;   // output scaling shift
  localparam int c_DEPTH = 1 << AVG_LOG2;
  localparam int c_SUM_W = CAR_W + AVG_LOG2;

  localparam logic [OUT_W-1:0]  c_OUT_MID = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [MSG_W-1:0]  c_MSG_MAX = {1'b0, {(MSG_W-1){1'b1}}};
  localparam logic [MSG_W-1:0]  c_MSG_MIN = {1'b1, {(MSG_W-1){1'b0}}};
  localparam logic [AVG_LOG2:0] c_FULL    = {1'b1, {AVG_LOG2{1'b0}}};
  localparam logic [AVG_LOG2:0] c_FILL_1  = {{AVG_LOG2{1'b0}}, 1'b1};
  localparam logic [AVG_LOG2-1:0] c_PTR_1 = {{(AVG_LOG2-1){1'b0}}, 1'b1};

  // Mode tracking and flush. r_mode follows mode every cycle, so a change is
  // seen for exactly one cycle; that cycle flushes everything downstream.
  logic r_mode;
  logic w_flush;
  logic w_acc;

  assign w_flush = (mode != r_mode);
  assign w_acc   = !w_flush && (mode ? car_valid : (msg_valid && car_valid));

  // Stage 0: captured and converted inputs
  logic                     r_s0_valid;
  logic signed [MSG_W-1:0]  r_s0_msg;
  logic signed [CAR_W-1:0]  r_s0_car;
  logic [GAIN_W-1:0]        r_s0_gain;

  // Stage 1: scaled message / rectified RF
  logic                     r_s1_valid;
  logic signed [MSG_W-1:0]  r_s1_m;
  logic signed [CAR_W-1:0]  r_s1_car;
  logic [CAR_W-1:0]         r_s1_r;

  // Stage 2: carrier product / boxcar state
  logic                     r_s2_valid;
  logic signed [c_P2W-1:0]  r_s2_p;
  logic [c_SUM_W-1:0]       r_sum;
  logic [CAR_W-1:0]         r_buf [c_DEPTH];
  logic [AVG_LOG2-1:0]      r_ptr;
  logic [AVG_LOG2:0]        r_fill;

  // Output stage
  logic [OUT_W-1:0]         r_out_data;
  logic                     r_out_valid;
  logic                     r_sat;

  // Stage 1 combinational: gain scaling with saturation, and rectification.
  logic signed [c_PW-1:0]   w_prod1;
  logic signed [c_PW-1:0]   w_sh1;
  logic                     w_ovf1;
  logic signed [MSG_W-1:0]  w_m1;
  logic [CAR_W-1:0]         w_r1;

  assign w_prod1 = c_PW'(r_s0_msg) * c_PW'($signed({1'b0, r_s0_gain}));
  assign w_sh1   = w_prod1 >>> 2;
  // Result fits MSG_W signed only if every bit from MSG_W-1 upward matches.
  assign w_ovf1  = !((&w_sh1[c_PW-1:MSG_W-1]) || !(|w_sh1[c_PW-1:MSG_W-1]));
  assign w_m1    = w_ovf1 ? (w_sh1[c_PW-1] ? c_MSG_MIN : c_MSG_MAX)
                          : w_sh1[MSG_W-1:0];
  // Two's complement negate in CAR_W bits: the most negative code becomes
  // 2^(CAR_W-1), which is the correct unsigned magnitude.
  assign w_r1    = r_s0_car[CAR_W-1] ? (~$unsigned(r_s0_car) + {{(CAR_W-1){1'b0}}, 1'b1})
                                     : $unsigned(r_s0_car);

  // Stage 2 combinational: offset to unsigned and multiply by the carrier.
  logic [MSG_W-1:0]         w_e2;
  logic signed [c_P2W-1:0]  w_p2;

  assign w_e2 = {~r_s1_m[MSG_W-1], r_s1_m[MSG_W-2:0]};
  assign w_p2 = c_P2W'($signed({1'b0, w_e2})) * c_P2W'(r_s1_car);

  always_ff @(posedge CLK) begin
    r_mode <= mode;
    if (!RST_n || w_flush) begin
      r_s0_valid  <= 1'b0;
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_sat       <= 1'b0;
      r_sum       <= '0;
      r_ptr       <= '0;
      r_fill      <= '0;
      for (int i = 0; i < c_DEPTH; i++) begin
        r_buf[i] <= '0;
      end
      // A flush holds the last output word; only reset returns it to midscale.
      if (!RST_n) begin
        r_out_data <= c_OUT_MID;
      end
    end else begin
      // Stage 0
      r_s0_valid <= w_acc;
      if (w_acc) begin
        r_s0_msg  <= {~msg_data[MSG_W-1], msg_data[MSG_W-2:0]};
        r_s0_car  <= {~car_data[CAR_W-1], car_data[CAR_W-2:0]};
        r_s0_gain <= gain;
      end

      // Stage 1
      r_s1_valid <= r_s0_valid;
      if (r_s0_valid) begin
        r_s1_m   <= w_m1;
        r_s1_car <= r_s0_car;
        r_s1_r   <= w_r1;
        if (!r_mode && w_ovf1) begin
          r_sat <= 1'b1;
        end
      end

      // Stage 2
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        if (!r_mode) begin
          r_s2_p <= w_p2;
        end else begin
          r_sum        <= r_sum + c_SUM_W'(r_s1_r) - c_SUM_W'(r_buf[r_ptr]);
          r_buf[r_ptr] <= r_s1_r;
          r_ptr        <= r_ptr + c_PTR_1;
          if (r_fill != c_FULL) begin
            r_fill <= r_fill + c_FILL_1;
          end
        end
      end

      // Stage 3
      r_out_valid <= 1'b0;
      if (r_s2_valid) begin
        if (!r_mode) begin
          r_out_data  <= OUT_W'(r_s2_p >>> c_SH) + c_OUT_MID;
          r_out_valid <= 1'b1;
        end else if (r_fill == c_FULL) begin
          // r_fill already includes this sample, so the first strobe lands
          // on the sample that completes the window.
          r_out_data  <= OUT_W'(r_sum >> AVG_LOG2) << (OUT_W - CAR_W);
          r_out_valid <= 1'b1;
        end
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign sat_flag  = r_sat;

`ifdef AM_DEPTH_METER_EN
  // Depth meter: min/max of the offset message e over each window of
  // 2^METER_LOG2 accepted modulate samples.
  localparam logic [METER_LOG2-1:0] c_MCNT_1 = {{(METER_LOG2-1){1'b0}}, 1'b1};

  logic [METER_LOG2-1:0] r_mcnt;
  logic [MSG_W-1:0]      r_tmax;
  logic [MSG_W-1:0]      r_tmin;
  logic [MSG_W-1:0]      r_env_max;
  logic [MSG_W-1:0]      r_env_min;
  logic                  r_meter_valid;
  logic [MSG_W-1:0]      w_nmax;
  logic [MSG_W-1:0]      w_nmin;

  assign w_nmax = (w_e2 > r_tmax) ? w_e2 : r_tmax;
  assign w_nmin = (w_e2 < r_tmin) ? w_e2 : r_tmin;

  always_ff @(posedge CLK) begin
    if (!RST_n || w_flush) begin
      r_mcnt        <= '0;
      r_tmax        <= '0;
      r_tmin        <= '1;
      r_meter_valid <= 1'b0;
      if (!RST_n) begin
        r_env_max <= '0;
        r_env_min <= '1;
      end
    end else begin
      r_meter_valid <= 1'b0;
      if (r_s1_valid && !r_mode) begin
        if (&r_mcnt) begin
          r_env_max     <= w_nmax;
          r_env_min     <= w_nmin;
          r_meter_valid <= 1'b1;
          r_tmax        <= '0;
          r_tmin        <= '1;
          r_mcnt        <= '0;
        end else begin
          r_tmax <= w_nmax;
          r_tmin <= w_nmin;
          r_mcnt <= r_mcnt + c_MCNT_1;
        end
      end
    end
  end

  assign env_max     = r_env_max;
  assign env_min     = r_env_min;
  assign meter_valid = r_meter_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_am_modem_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_am_modem_core
// Purpose  : Self-checking bench for am_modem_core (default parameters,
//            depth meter disabled). Table-driven modulate vectors plus
//            directed sequences for warm-up, flush, gaps and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_am_modem_core;

  logic        CLK;
  logic        RST_n;
  logic        mode;
  logic [3:0]  gain;
  logic [11:0] msg_data;
  logic        msg_valid;
  logic [7:0]  car_data;
  logic        car_valid;
  logic [13:0] out_data;
  logic        out_valid;
  logic        sat_flag;

  int n_checks;
  int n_fail;

  am_modem_core u_dut (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .mode      (mode),
    .gain      (gain),
    .msg_data  (msg_data),
    .msg_valid (msg_valid),
    .car_data  (car_data),
    .car_valid (car_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .sat_flag  (sat_flag)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [11:0] msg;
    logic [3:0]  gain;
    logic [7:0]  car;
    logic [13:0] exp_out;
    logic        exp_sat;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected demodulated output for stream sample j: samples 0..31 alternate
  // 0xC0/0x40 (magnitude 64), later samples are 0x00 (magnitude 128).
  function automatic logic [13:0] demod_exp(input int j);
    int nz;
    nz = (j < 32) ? 0 : ((j - 31 > 16) ? 16 : j - 31);
    return 14'(((64 * (16 - nz) + 128 * nz) / 16) * 64);
  endfunction

  initial begin
    int early;
    int strobes;
    int j;
    logic exp_v;

    n_checks = 0;
    n_fail   = 0;

    vecs[0]  = '{12'h800, 4'd4,  8'hFF, 14'h2FE0, 1'b0};
    vecs[1]  = '{12'hFFF, 4'd4,  8'hFF, 14'h3FBE, 1'b0};
    vecs[2]  = '{12'hFFF, 4'd4,  8'h00, 14'h0002, 1'b0};
    vecs[3]  = '{12'h123, 4'd0,  8'hC0, 14'h2800, 1'b0};
    vecs[4]  = '{12'hC00, 4'd2,  8'h90, 14'h2280, 1'b0};
    vecs[5]  = '{12'h801, 4'd4,  8'h7F, 14'h1FDF, 1'b0};
    vecs[6]  = '{12'h7FF, 4'd1,  8'hFF, 14'h2FDE, 1'b0};
    vecs[7]  = '{12'h400, 4'd8,  8'hFF, 14'h2000, 1'b0};
    vecs[8]  = '{12'hFFF, 4'd15, 8'hFF, 14'h3FBE, 1'b1};
    vecs[9]  = '{12'h000, 4'd15, 8'h80, 14'h2000, 1'b1};
    vecs[10] = '{12'h3FF, 4'd8,  8'hFF, 14'h2000, 1'b1};

    RST_n = 1'b0; mode = 1'b0; gain = 4'd0;
    msg_data = '0; msg_valid = 1'b0; car_data = '0; car_valid = 1'b0;

    // ---------------- reset state ----------------
    repeat (3) @(negedge CLK);
    check("reset_out_data", 32'(out_data), 32'h2000);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_sat_flag", 32'(sat_flag), 32'd0);
    RST_n = 1'b1;
    repeat (2) @(negedge CLK);

    // ---------------- modulate vector table ----------------
    for (int v = 0; v < 11; v++) begin
      msg_data = vecs[v].msg; gain = vecs[v].gain; car_data = vecs[v].car;
      msg_valid = 1'b1; car_valid = 1'b1;
      early = 0;
      for (int k = 0; k < 5; k++) begin
        @(negedge CLK);
        if (k == 0) begin
          msg_valid = 1'b0; car_valid = 1'b0;
        end
        if (k < 3 && out_valid) early++;
        if (k == 3) begin
          check($sformatf("mod%0d_valid_lat3", v), 32'(out_valid), 32'd1);
          check($sformatf("mod%0d_out_data", v), 32'(out_data), 32'(vecs[v].exp_out));
          check($sformatf("mod%0d_sat_flag", v), 32'(sat_flag), 32'(vecs[v].exp_sat));
        end
        if (k == 4) check($sformatf("mod%0d_strobe_width", v), 32'(out_valid), 32'd0);
      end
      check($sformatf("mod%0d_early_strobe", v), early, 0);
    end

    // ---------------- demodulate warm-up and averaging ----------------
    mode = 1'b1;
    for (int k = 0; k < 68; k++) begin
      @(negedge CLK);
      if (k == 0) check("demod_flush_clears_sat", 32'(sat_flag), 32'd0);
      j = k - 4;
      exp_v = (j >= 15 && j <= 63);
      check($sformatf("demod_valid_s%0d", j), 32'(out_valid), 32'(exp_v));
      if (exp_v) check($sformatf("demod_data_s%0d", j), 32'(out_data), 32'(demod_exp(j)));
      car_valid = (k < 64);
      car_data  = (k < 32) ? ((k % 2 != 0) ? 8'h40 : 8'hC0) : 8'h00;
    end
    car_valid = 1'b0;

    // ---------------- demod -> modulate with samples in flight ----------------
    @(negedge CLK);
    car_data = 8'hC0;
    car_valid = 1'b1;
    repeat (3) @(negedge CLK);
    mode = 1'b0;
    car_valid = 1'b0;
    strobes = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      if (out_valid) strobes++;
    end
    check("toggle1_flushed_strobes", strobes, 0);
    check("toggle1_out_data_held", 32'(out_data), 32'h2000);

    // ---------------- modulate -> demod: sat clear, warm-up restart ----------
    msg_data = 12'hFFF; gain = 4'd15; car_data = 8'hFF;
    msg_valid = 1'b1; car_valid = 1'b1;
    @(negedge CLK);
    msg_valid = 1'b0; car_valid = 1'b0;
    @(negedge CLK);
    check("toggle2_sat_before", 32'(sat_flag), 32'd1);
    mode = 1'b1; car_data = 8'hC0; car_valid = 1'b1; msg_valid = 1'b1;
    for (int k = 0; k < 22; k++) begin
      @(negedge CLK);
      msg_valid = 1'b0;
      if (k == 0) check("toggle2_sat_cleared", 32'(sat_flag), 32'd0);
      j = k - 4;
      exp_v = (j >= 15 && j <= 15);
      check($sformatf("toggle2_valid_s%0d", j), 32'(out_valid), 32'(exp_v));
      if (exp_v) check("toggle2_first_env", 32'(out_data), 32'h1000);
      car_valid = (k < 16);
    end
    car_valid = 1'b0;

    // ---------------- lone msg_valid in modulate ----------------
    mode = 1'b0;
    @(negedge CLK);
    msg_data = 12'h900; gain = 4'd4; msg_valid = 1'b1;
    strobes = 0;
    for (int k = 0; k < 13; k++) begin
      @(negedge CLK);
      if (k == 9) msg_valid = 1'b0;
      if (out_valid) strobes++;
    end
    check("lone_msg_valid_strobes", strobes, 0);

    // ---------------- gapped valids, one in three ----------------
    for (int c = 0; c < 16; c++) begin
      @(negedge CLK);
      exp_v = (c >= 4 && (c - 4) % 3 == 0 && (c - 4) / 3 < 4);
      check($sformatf("gap_valid_c%0d", c), 32'(out_valid), 32'(exp_v));
      if (exp_v) check($sformatf("gap_data_c%0d", c), 32'(out_data), 32'(vecs[(c - 4) / 3].exp_out));
      if (c % 3 == 0 && c / 3 < 4) begin
        msg_data = vecs[c / 3].msg; gain = vecs[c / 3].gain; car_data = vecs[c / 3].car;
        msg_valid = 1'b1; car_valid = 1'b1;
      end else begin
        msg_valid = 1'b0; car_valid = 1'b0;
      end
    end

    // ---------------- reset mid-stream ----------------
    msg_data = vecs[8].msg; gain = vecs[8].gain; car_data = vecs[8].car;
    msg_valid = 1'b1; car_valid = 1'b1;
    @(negedge CLK);
    msg_data = vecs[0].msg; gain = vecs[0].gain; car_data = vecs[0].car;
    @(negedge CLK);
    check("rst_mid_sat_before", 32'(sat_flag), 32'd1);
    RST_n = 1'b0;
    @(negedge CLK);
    check("rst_mid_out_data", 32'(out_data), 32'h2000);
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_sat_flag", 32'(sat_flag), 32'd0);
    RST_n = 1'b1; msg_valid = 1'b0; car_valid = 1'b0;
    strobes = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      if (out_valid) strobes++;
    end
    check("rst_mid_stale_strobes", strobes, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
